// File: rtl/round_robin_fifo_distributor.sv
// Deals a single write stream in strict rotation into four independent FIFOs (a, b, c, d).
// Each channel drains on its own read enable; outputs are zero whenever not valid.
module round_robin_fifo_distributor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       ren,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       valid,
  output logic             wr_error,
  output logic [3:0]       full,
  output logic [3:0]       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [PTR_W-1:0] head [4];
  logic [PTR_W-1:0] tail [4];
  logic [CNT_W-1:0] count [4];
  logic [WIDTH-1:0] rd_data [4];
  logic [1:0]       sel;

  logic       wr_acc;
  logic [3:0] wr_ch;
  logic [3:0] rd_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    full  = '0;
    empty = '0;
    wr_ch = '0;
    rd_ok = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]  = (count[i] == FULL_CNT);
      empty[i] = (count[i] == '0);
    end
    // A full target still accepts when the same edge reads from it.
    wr_acc = rst_n && wen && (!full[sel] || ren[sel]);
    for (int i = 0; i < 4; i++) begin
      wr_ch[i] = wr_acc && (sel == 2'(i));
      rd_ok[i] = rst_n && ren[i] && !empty[i];
    end
  end

  // NOTE: storage has no reset; clearing pointers and counts is enough to discard contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_ch[i]) mem[i][tail[i]] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel      <= '0;
      wr_error <= 1'b0;
      valid    <= '0;
      for (int i = 0; i < 4; i++) begin
        head[i]    <= '0;
        tail[i]    <= '0;
        count[i]   <= '0;
        rd_data[i] <= '0;
      end
    end else begin
      sel      <= sel + 2'(wr_acc);
      wr_error <= wen && !wr_acc;
      valid    <= rd_ok;
      for (int i = 0; i < 4; i++) begin
        if (wr_ch[i]) tail[i] <= tail[i] + 1'b1;
        if (rd_ok[i]) begin
          head[i]    <= head[i] + 1'b1;
          rd_data[i] <= mem[i][head[i]];
        end else begin
          rd_data[i] <= '0;
        end
        case ({wr_ch[i], rd_ok[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign a = rd_data[0];
  assign b = rd_data[1];
  assign c = rd_data[2];
  assign d = rd_data[3];

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Scoreboard bench for round_robin_fifo_distributor: a behavioural model pushes expected
// words per channel at write time and pops them when the DUT should present them.
module tb_round_robin_fifo_distributor;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wen = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [3:0]       ren = '0;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       valid, full, empty;
  logic             wr_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] exp_q [4][$];
  int               mcount [4];
  logic [1:0]       msel;

  round_robin_fifo_distributor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren),
    .a(a), .b(b), .c(c), .d(d),
    .valid(valid), .wr_error(wr_error), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] chan(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mcount[i] == DEPTH);
    return f;
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mcount[i] == 0);
    return e;
  endfunction

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic step(input logic w, input logic [WIDTH-1:0] dv, input logic [3:0] r);
    logic             acc;
    logic [3:0]       ev;
    logic [WIDTH-1:0] ed [4];
    wen = w; din = dv; ren = r;
    acc = w && ((mcount[msel] < DEPTH) || r[msel]);
    for (int i = 0; i < 4; i++) begin
      ev[i] = r[i] && (mcount[i] > 0);
      ed[i] = '0;
      if (ev[i]) begin
        ed[i] = exp_q[i].pop_front();
        mcount[i]--;
      end
    end
    if (acc) begin
      exp_q[msel].push_back(dv);
      mcount[msel]++;
      msel++;
    end
    @(posedge clk); #1;
    check("valid", 32'(valid), 32'(ev));
    check("wr_error", 32'(wr_error), 32'(w && !acc));
    check("full", 32'(full), 32'(model_full()));
    check("empty", 32'(empty), 32'(model_empty()));
    for (int i = 0; i < 4; i++) check($sformatf("data_ch%0d", i), 32'(chan(i)), 32'(ed[i]));
  endtask

  task automatic do_reset(input logic w, input logic [WIDTH-1:0] dv);
    rst_n = 1'b0; wen = w; din = dv; ren = 4'hf;
    @(posedge clk); #1;
    rst_n = 1'b1; wen = 1'b0; ren = '0;
    msel = '0;
    for (int i = 0; i < 4; i++) begin
      mcount[i] = 0;
      exp_q[i].delete();
    end
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_wr_error", 32'(wr_error), 32'h0);
    check("rst_empty", 32'(empty), 32'hf);
    check("rst_full", 32'(full), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_data_ch%0d", i), 32'(chan(i)), 32'h0);
  endtask

  initial begin
    msel = '0;
    for (int i = 0; i < 4; i++) mcount[i] = 0;

    // Reset state.
    do_reset(1'b0, '0);

    // Ordering: 1..8 then three cycles of reading all channels.
    for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 4'h0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 4'hf);

    // Overflow: fill all four channels, reject, then accept with a simultaneous read.
    do_reset(1'b0, '0);
    for (int i = 1; i <= 4 * DEPTH; i++) step(1'b1, WIDTH'(i), 4'h0);
    check("ovf_full", 32'(full), 32'hf);
    step(1'b1, 8'hAA, 4'h0);
    step(1'b1, 8'hBB, 4'h1);
    check("ovf_sel_after_bb", 32'(msel), 32'h1);
    for (int k = 0; k < DEPTH + 1; k++) step(1'b0, '0, 4'hf);

    // Empty read with simultaneous write: no bypass.
    do_reset(1'b0, '0);
    step(1'b1, 8'h11, 4'hf);
    step(1'b0, '0, 4'h1);

    // Wrap-around: three rounds of full fill then rotating drain.
    do_reset(1'b0, '0);
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 4 * DEPTH; i++) step(1'b1, WIDTH'($urandom), 4'h0);
      for (int k = 0; k < 4 * DEPTH; k++) step(1'b0, '0, 4'(1 << (k % 4)));
    end
    check("wrap_empty", 32'(empty), 32'hf);

    // Reset mid-operation with wen asserted.
    do_reset(1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h20 + i), 4'h0);
    do_reset(1'b1, 8'h77);
    step(1'b1, 8'h5A, 4'h0);
    step(1'b0, '0, 4'h1);

    // Random traffic to exercise concurrent writes, reads and rejects.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 4'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
